// File: rtl/mem_arbiter_n_pkg.sv
// Shared types and default constants for the N-port memory arbiter.
package mem_arbiter_n_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_PORTS  = 2;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LINE_WIDTH = 256;

  // The index type is sized for the largest supported port count so that it
  // can be shared by every instance regardless of NUM_PORTS.
  localparam int MAX_NUM_PORTS = 8;
  localparam int PORT_IDX_W    = $clog2(MAX_NUM_PORTS);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/mem_arbiter_n_picker.sv
// Combinational winner selection: first requesting index strictly after ptr,
// wrapping around. A ptr of NUM_PORTS-1 degenerates to lowest-index priority.
module arb_picker
  import mem_arbiter_n_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output logic [NUM_PORTS-1:0] grant,
  output port_idx_t            idx,
  output logic                 any
);

  logic      hi_any;
  port_idx_t hi_idx;
  port_idx_t lo_idx;

  // Descending scan leaves the lowest match in each half.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_idx = port_idx_t'(k);
        if (k > int'(ptr)) begin
          hi_any = 1'b1;
          hi_idx = port_idx_t'(k);
        end
      end
    end
  end

  assign any = |req;
  assign idx = hi_any ? hi_idx : lo_idx;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_grant
    assign grant[gi] = any && (idx == port_idx_t'(gi));
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port cache-to-memory arbiter with a latched single outstanding request.
// Define MEM_ARB_RR_EN for round-robin selection; otherwise fixed priority.
module mem_arbiter_n
  import mem_arbiter_n_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] port_wdata,
  input  logic [NUM_PORTS-1:0]                 port_read,
  input  logic [NUM_PORTS-1:0]                 port_write,
  output logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] port_rdata,
  output logic [NUM_PORTS-1:0]                 port_resp,
  output logic [ADDR_WIDTH-1:0]                pmem_addr,
  output logic [LINE_WIDTH-1:0]                pmem_wdata,
  output logic                                 pmem_read,
  output logic                                 pmem_write,
  input  logic [LINE_WIDTH-1:0]                pmem_rdata,
  input  logic                                 pmem_resp
);

  localparam port_idx_t LAST_PORT = port_idx_t'(NUM_PORTS - 1);

  arb_state_t            state_reg, state_next;
  port_idx_t             win_idx_reg, win_idx_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  read_reg, read_next;
  logic                  write_reg, write_next;
  port_idx_t             ptr;

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  grant;
  port_idx_t             pick_idx;
  logic                  pick_any;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_wdata;
  logic                  sel_read;
  logic                  sel_write;

`ifdef MEM_ARB_RR_EN
  port_idx_t ptr_reg, ptr_next;
  assign ptr = ptr_reg;
`else
  assign ptr = LAST_PORT;
`endif

  assign req = port_read | port_write;

  arb_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant[k]) begin
        sel_addr  = port_addr[k];
        sel_wdata = port_wdata[k];
        sel_read  = port_read[k];
        sel_write = port_write[k];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    win_idx_next = win_idx_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    read_next    = read_reg;
    write_next   = write_reg;
`ifdef MEM_ARB_RR_EN
    ptr_next     = ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next   = BUSY;
          win_idx_next = pick_idx;
          addr_next    = sel_addr;
          wdata_next   = sel_wdata;
          // A simultaneous read+write is treated as a write.
          read_next    = sel_read && !sel_write;
          write_next   = sel_write;
`ifdef MEM_ARB_RR_EN
          ptr_next     = pick_idx;
`endif
        end
      end
      BUSY: begin
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      win_idx_reg <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      read_reg    <= 1'b0;
      write_reg   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      ptr_reg     <= LAST_PORT;
`endif
    end else begin
      state_reg   <= state_next;
      win_idx_reg <= win_idx_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      read_reg    <= read_next;
      write_reg   <= write_next;
`ifdef MEM_ARB_RR_EN
      ptr_reg     <= ptr_next;
`endif
    end
  end

  // Downstream sees only latched values, and nothing at all while IDLE.
  logic busy, resp_cycle;
  assign busy       = (state_reg == BUSY);
  assign resp_cycle = busy && pmem_resp;
  assign pmem_addr  = busy ? addr_reg : '0;
  assign pmem_wdata = busy ? wdata_reg : '0;
  assign pmem_read  = busy && read_reg;
  assign pmem_write = busy && write_reg;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_out
    assign port_resp[gi]  = resp_cycle && (win_idx_reg == port_idx_t'(gi));
    assign port_rdata[gi] = port_resp[gi] ? pmem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench for mem_arbiter_n: stimulus queues expected downstream
// requests and port responses; a negedge monitor pops and compares them.
module tb_mem_arbiter_n;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 256;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [LW-1:0] wdata;
  } req_t;

  typedef struct {
    int            port;
    logic [LW-1:0] data;
  } rsp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NP-1:0][AW-1:0] port_addr;
  logic [NP-1:0][LW-1:0] port_wdata;
  logic [NP-1:0]         port_read;
  logic [NP-1:0]         port_write;
  logic [NP-1:0][LW-1:0] port_rdata;
  logic [NP-1:0]         port_resp;
  logic [AW-1:0]         pmem_addr;
  logic [LW-1:0]         pmem_wdata;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [LW-1:0]         pmem_rdata;
  logic                  pmem_resp;

  mem_arbiter_n #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .port_read  (port_read),
    .port_write (port_write),
    .port_rdata (port_rdata),
    .port_resp  (port_resp),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  req_t          exp_req_q[$];
  rsp_t          exp_rsp_q[$];
  logic [LW-1:0] mem_q[$];

  logic          cfg_rd[NP];
  logic          cfg_wr[NP];
  logic [AW-1:0] cfg_addr[NP];
  logic [LW-1:0] cfg_wdata[NP];
  int            issued[NP];
  int            done[NP];

  logic resp_en;
  int   lat;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rdata_or();
    logic [LW-1:0] o;
    o = '0;
    for (int p = 0; p < NP; p++) o |= port_rdata[p];
    return o;
  endfunction

  // Port driver: holds each port's request until its port_resp is seen.
  initial begin
    for (int p = 0; p < NP; p++) begin
      cfg_rd[p] = 1'b0; cfg_wr[p] = 1'b0; cfg_addr[p] = '0; cfg_wdata[p] = '0;
      issued[p] = 0; done[p] = 0;
    end
    port_read = '0; port_write = '0; port_addr = '0; port_wdata = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (port_resp[p]) done[p]++;
        port_read[p]  = (done[p] < issued[p]) && cfg_rd[p];
        port_write[p] = (done[p] < issued[p]) && cfg_wr[p];
        port_addr[p]  = cfg_addr[p];
        port_wdata[p] = cfg_wdata[p];
      end
    end
  end

  // Memory model: answers lat cycles into each request with the next mem_q line.
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        cnt = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        cnt = 0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= lat) begin
          pmem_resp = 1'b1;
          pmem_rdata = (mem_q.size() > 0) ? mem_q.pop_front() : '0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_act;
    logic act;
    req_t cur;
    rsp_t r;
    logic [NP-1:0] exp_vec;
    logic [LW-1:0] others;
    prev_act = 1'b0;
    cur = '{addr: '0, rd: 1'b0, wr: 1'b0, wdata: '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_act = 1'b0;
        continue;
      end
      act = pmem_read || pmem_write;
      if (act && !prev_act) begin
        if (exp_req_q.size() == 0) begin
          chk("unexpected_issue", {{(LW-AW){1'b0}}, pmem_addr}, '1);
        end else begin
          cur = exp_req_q.pop_front();
          chk("issue_addr", {{(LW-AW){1'b0}}, pmem_addr}, {{(LW-AW){1'b0}}, cur.addr});
          chk("issue_read", {{(LW-1){1'b0}}, pmem_read}, {{(LW-1){1'b0}}, cur.rd});
          chk("issue_write", {{(LW-1){1'b0}}, pmem_write}, {{(LW-1){1'b0}}, cur.wr});
          chk("issue_wdata", pmem_wdata, cur.wdata);
        end
      end else if (act) begin
        chk("hold_addr", {{(LW-AW){1'b0}}, pmem_addr}, {{(LW-AW){1'b0}}, cur.addr});
        chk("hold_wdata", pmem_wdata, cur.wdata);
      end else begin
        chk("idle_addr", {{(LW-AW){1'b0}}, pmem_addr}, '0);
        chk("idle_wdata", pmem_wdata, '0);
      end
      prev_act = act;
      if (|port_resp) begin
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_resp", {{(LW-NP){1'b0}}, port_resp}, '0);
        end else begin
          r = exp_rsp_q.pop_front();
          exp_vec = '0;
          exp_vec[r.port] = 1'b1;
          others = '0;
          for (int p = 0; p < NP; p++) if (p != r.port) others |= port_rdata[p];
          chk("resp_vec", {{(LW-NP){1'b0}}, port_resp}, {{(LW-NP){1'b0}}, exp_vec});
          chk("resp_data", port_rdata[r.port], r.data);
          chk("resp_other_rdata", others, '0);
          $display("resp port %0d data %0h", r.port, port_rdata[r.port]);
        end
      end else begin
        chk("quiet_rdata", rdata_or(), '0);
      end
    end
  end

  task automatic issue(input int p, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [LW-1:0] wd, input int n);
    cfg_rd[p] = rd;
    cfg_wr[p] = wr;
    cfg_addr[p] = a;
    cfg_wdata[p] = wd;
    issued[p] = issued[p] + n;
  endtask

  task automatic expect_txn(input int p, input logic [AW-1:0] a, input logic rd, input logic wr,
                            input logic [LW-1:0] wd, input logic [LW-1:0] data);
    exp_req_q.push_back('{addr: a, rd: rd, wr: wr, wdata: wd});
    exp_rsp_q.push_back('{port: p, data: data});
    mem_q.push_back(data);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    logic idle;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      idle = (exp_req_q.size() == 0) && (exp_rsp_q.size() == 0) && !pmem_read && !pmem_write;
      for (int p = 0; p < NP; p++) if (done[p] < issued[p]) idle = 1'b0;
      if (idle) break;
    end
    chk({nm, "_req_left"}, LW'(exp_req_q.size()), '0);
    chk({nm, "_rsp_left"}, LW'(exp_rsp_q.size()), '0);
  endtask

  initial begin
    int order[6];
    logic [AW-1:0] rr_addr[NP];
    logic [LW-1:0] d;
    rr_addr[0] = 32'h0000_1000; rr_addr[1] = 32'h0000_2000;
    rr_addr[2] = 32'h0000_3000; rr_addr[3] = 32'h0000_4000;
`ifdef MEM_ARB_RR_EN
    order = '{0, 2, 3, 0, 2, 3};
`else
    order = '{0, 0, 2, 2, 3, 3};
`endif
    rst = 1'b1; resp_en = 1'b1; lat = 3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_pmem_read", {{(LW-1){1'b0}}, pmem_read}, '0);
    chk("rst_pmem_write", {{(LW-1){1'b0}}, pmem_write}, '0);
    chk("rst_pmem_addr", {{(LW-AW){1'b0}}, pmem_addr}, '0);
    chk("rst_port_resp", {{(LW-NP){1'b0}}, port_resp}, '0);
    chk("rst_port_rdata", rdata_or(), '0);

    // Single read on port 1
    @(posedge clk); #1;
    d = {32{8'hA5}};
    expect_txn(1, 32'h0000_1040, 1'b1, 1'b0, '0, d);
    issue(1, 1'b1, 1'b0, 32'h0000_1040, '0, 1);
    @(negedge clk); @(negedge clk);
    chk("lat1_pmem_read", {{(LW-1){1'b0}}, pmem_read}, {{(LW-1){1'b0}}, 1'b1});
    drain("single_read", 50);

    // Simultaneous requests from ports 0 and 1
    reset_dut();
    lat = 2;
    expect_txn(0, 32'h0000_0100, 1'b1, 1'b0, '0, {32{8'h11}});
    expect_txn(1, 32'h0000_0200, 1'b1, 1'b0, '0, {32{8'h22}});
    issue(0, 1'b1, 1'b0, 32'h0000_0100, '0, 1);
    issue(1, 1'b1, 1'b0, 32'h0000_0200, '0, 1);
    drain("simul", 50);

    // Continuous requests from ports 0, 2, 3
    reset_dut();
    lat = 1;
    for (int k = 0; k < 6; k++) begin
      d = {32{8'(8'h30 + k)}};
      expect_txn(order[k], rr_addr[order[k]], 1'b1, 1'b0, '0, d);
    end
    issue(0, 1'b1, 1'b0, rr_addr[0], '0, 2);
    issue(2, 1'b1, 1'b0, rr_addr[2], '0, 2);
    issue(3, 1'b1, 1'b0, rr_addr[3], '0, 2);
    drain("arb_order", 100);

    // Latching: port 2 moves its address while BUSY
    @(posedge clk); #1;
    lat = 4;
    expect_txn(2, 32'h0000_0200, 1'b0, 1'b1, {8{32'hCAFE_0200}}, {64{4'h3}});
    issue(2, 1'b0, 1'b1, 32'h0000_0200, {8{32'hCAFE_0200}}, 1);
    @(negedge clk); @(negedge clk);
    cfg_addr[2] = 32'h0000_0300;
    cfg_wdata[2] = {8{32'hDEAD_0300}};
    drain("latch", 50);

    // Reset two cycles into a read, then a late pmem_resp
    @(posedge clk); #1;
    resp_en = 1'b0;
    exp_req_q.push_back('{addr: 32'h0000_0500, rd: 1'b1, wr: 1'b0, wdata: '0});
    issue(1, 1'b1, 1'b0, 32'h0000_0500, '0, 1);
    @(negedge clk); @(negedge clk);
    chk("abort_busy_read", {{(LW-1){1'b0}}, pmem_read}, {{(LW-1){1'b0}}, 1'b1});
    @(posedge clk); #1;
    rst = 1'b1;
    issued[1] = done[1];
    @(posedge clk); #1;
    rst = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = {32{8'hEE}};
    @(negedge clk);
    chk("abort_port_resp", {{(LW-NP){1'b0}}, port_resp}, '0);
    chk("abort_pmem_read", {{(LW-1){1'b0}}, pmem_read}, '0);
    chk("abort_rdata", rdata_or(), '0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    resp_en = 1'b1;
    lat = 2;
    expect_txn(3, 32'h0000_0600, 1'b1, 1'b0, '0, {32{8'h66}});
    issue(3, 1'b1, 1'b0, 32'h0000_0600, '0, 1);
    drain("after_abort", 50);

    // Read and write together on port 0, then a stray pmem_resp in IDLE
    @(posedge clk); #1;
    expect_txn(0, 32'h0000_0700, 1'b0, 1'b1, {8{32'h0BAD_F00D}}, {32{8'h77}});
    issue(0, 1'b1, 1'b1, 32'h0000_0700, {8{32'h0BAD_F00D}}, 1);
    drain("rw_both", 50);
    @(posedge clk); #1;
    resp_en = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = {32{8'h99}};
    @(negedge clk);
    chk("stray_port_resp", {{(LW-NP){1'b0}}, port_resp}, '0);
    chk("stray_rdata", rdata_or(), '0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    resp_en = 1'b1;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of cache ports (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 SHALL have parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port port_addr  input  NUM_PORTS x ADDR_WIDTH  per-port line address.
REQ-007 SHALL have port port_wdata  input  NUM_PORTS x LINE_WIDTH  per-port write line.
REQ-008 SHALL have port port_read / port_write  input  NUM_PORTS each  per-port request strobes.
REQ-009 SHALL have port port_rdata  output  NUM_PORTS x LINE_WIDTH  per-port read line.
REQ-010 SHALL have port port_resp  output  NUM_PORTS  per-port one-cycle completion pulse.
REQ-011 SHALL have port pmem_addr / pmem_wdata / pmem_read / pmem_write  output  ADDR_WIDTH / LINE_WIDTH / 1 / 1  downstream request.
REQ-012 SHALL have port pmem_rdata / pmem_resp  input  LINE_WIDTH / 1  downstream read data and completion.

Function
REQ-013 SHALL implement states IDLE and BUSY.
REQ-014 In IDLE, any port with port_read or port_write high SHALL be requesting; when at least one port requests, the arbiter SHALL pick one winner, latch its index, address, wdata, read and write into registers, and enter BUSY on the next edge.
REQ-015 In IDLE, all pmem_* outputs SHALL be 0 and every port_resp SHALL be 0.
REQ-016 In BUSY, pmem_addr, pmem_wdata, pmem_read and pmem_write SHALL come only from the latched registers, never from live port inputs.
REQ-017 In BUSY, when pmem_resp is 1, the arbiter SHALL pulse port_resp[winner] for exactly that cycle, drive port_rdata[winner] = pmem_rdata in that cycle, and return to IDLE.
REQ-018 port_rdata of non-granted ports, and of all ports outside the response cycle, SHALL be 0.
REQ-019 Minimum latency SHALL be 1 cycle from a request sampled in IDLE to pmem_read or pmem_write high, and 0 cycles from pmem_resp to port_resp.
REQ-020 Each port SHALL hold its request stable until its port_resp; the arbiter SHALL NOT capture a request more than once per transaction.
REQ-021 After a response there SHALL be one IDLE cycle; that cycle is the turnaround that lets the served port deassert its request.
REQ-022 If port_read and port_write are both high on the winning port, the write SHALL be issued and the read ignored.
REQ-023 pmem_resp received in IDLE SHALL be ignored.
REQ-024 Requests arriving on other ports while BUSY SHALL wait; they are not lost and are arbitrated in the next IDLE cycle.

Reset
REQ-025 A cycle with rst high SHALL force IDLE, clear all latched registers and clear the round-robin pointer to NUM_PORTS-1; after that edge, all outputs SHALL be 0.
REQ-026 A reset during BUSY SHALL abandon the transaction without any port_resp; a late pmem_resp then falls under REQ-023.

Configuration
REQ-027 With macro MEM_ARB_RR_EN defined, selection SHALL be round-robin: the winner is the first requesting index after the last granted index, wrapping modulo NUM_PORTS, and the pointer updates on each grant.
REQ-028 Without MEM_ARB_RR_EN, selection SHALL be fixed priority: the lowest requesting index wins, and no pointer register exists.

Structure
REQ-029 The shared package SHALL hold the state enum type, the default parameter constants and a port-index typedef of width $clog2(NUM_PORTS).
REQ-030 Winner selection SHALL be a combinational sub-module arb_picker, taking the request vector and pointer and returning a one-hot grant and an index.

Verification
REQ-031 Single read: port 1 reads addr 0x0000_1040, pmem_resp after 3 cycles with data 0xA5.. -> pmem_read high in cycle 1 with addr 0x1040; port_resp[1] and port_rdata[1] = 0xA5.. in the resp cycle; port 0 rdata stays 0.
REQ-032 Simultaneous requests: ports 0 and 1 request in cycle 0 with pointer at reset -> port 0 is served first, then port 1 after one IDLE cycle, with no request dropped.
REQ-033 Round-robin (MEM_ARB_RR_EN, NUM_PORTS=4): ports 0, 2 and 3 request continuously -> grants are 0,2,3,0,2,3; with the macro undefined, port 0 wins every time.
REQ-034 Latching: port 2 writes 0x200 then changes port_addr to 0x300 while BUSY -> pmem_addr stays 0x200 until pmem_resp.
REQ-035 Reset mid-BUSY: rst pulsed 2 cycles into a read, then pmem_resp arrives -> no port_resp, all outputs 0, and the next request is served normally.
REQ-036 Read and write both high on port 0 -> pmem_write=1, pmem_read=0; a stray pmem_resp in IDLE causes no port_resp.
